// File: rtl/spi_slave_frame_if.sv
// SPI pins plus the response-load and received-field handshakes of spi_slave_frame.
// The slave modport is the block's view; the master modport is the board/decoder side.
interface spi_slave_frame_if #(
  parameter int CMD_BITS     = 8,
  parameter int ADDR_BITS    = 8,
  parameter int PAYLOAD_BITS = 8,
  parameter int FRAME_W      = CMD_BITS + ADDR_BITS + PAYLOAD_BITS
);
  logic                    sclk;
  logic                    cs;
  logic                    mosi;
  logic                    miso;
  logic [FRAME_W-1:0]      i_tx_frame;
  logic                    i_tx_valid;
  logic                    o_tx_ack;
  logic                    o_rx_valid;
  logic [CMD_BITS-1:0]     o_cmd;
  logic [ADDR_BITS-1:0]    o_addr;
  logic [PAYLOAD_BITS-1:0] o_payload;
  logic                    o_frame_err;
  logic                    o_busy;

  modport slave (
    input  sclk, cs, mosi, i_tx_frame, i_tx_valid,
    output miso, o_tx_ack, o_rx_valid, o_cmd, o_addr, o_payload, o_frame_err, o_busy
  );

  modport master (
    output sclk, cs, mosi, i_tx_frame, i_tx_valid,
    input  miso, o_tx_ack, o_rx_valid, o_cmd, o_addr, o_payload, o_frame_err, o_busy
  );
endinterface

// File: rtl/spi_slave_frame.sv
// Full-duplex SPI slave for CMD|ADDR|PAYLOAD frames in any SPI mode, oversampled in sysclk.
// Pin-to-detect 3 cycles; fields and o_rx_valid one cycle after the final sample-edge detect.
module spi_slave_frame #(
  parameter int CMD_BITS     = 8,
  parameter int ADDR_BITS    = 8,
  parameter int PAYLOAD_BITS = 8,
  parameter int FRAME_W      = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0
) (
  input logic               sysclk,
  input logic               rst,
  spi_slave_frame_if.slave  bus
);
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state;
  logic [2:0]         sclk_sync;
  logic [2:0]         cs_sync;
  logic [1:0]         mosi_sync;
  logic [1:0]         guard;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] rx_sr;
  logic [FRAME_W-1:0] tx_sr;

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_high, mosi_s;
  logic [FRAME_W-1:0] rx_next;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sclk_sync <= {3{CPOL}};
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], bus.sclk};
      cs_sync   <= {cs_sync[1:0], bus.cs};
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

  assign sclk_edge   = sclk_sync[1] != sclk_sync[2];
  assign lead_edge   = sclk_edge && (sclk_sync[2] == CPOL);
  assign trail_edge  = sclk_edge && (sclk_sync[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = !cs_sync[1] && cs_sync[2];
  assign cs_high     = cs_sync[1];
  assign mosi_s      = mosi_sync[1];
  // The final bit goes straight into the field registers, so rx_sr only keeps FRAME_W-1 bits.
  assign rx_next     = {rx_sr, mosi_s};

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state           <= IDLE;
      guard           <= 2'd3;
      bit_cnt         <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      bus.miso        <= 1'b0;
      bus.o_tx_ack    <= 1'b0;
      bus.o_rx_valid  <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_cmd       <= '0;
      bus.o_addr      <= '0;
      bus.o_payload   <= '0;
    end else begin
      bus.o_tx_ack    <= 1'b0;
      bus.o_rx_valid  <= 1'b0;
      bus.o_frame_err <= 1'b0;
      if (guard != 2'd0) guard <= guard - 2'd1;

      case (state)
        IDLE: begin
          bus.miso   <= 1'b0;
          bus.o_busy <= 1'b0;
          if (cs_fall) begin
            // A fall seen while the synchronisers settle means cs was already low in reset.
            if (guard != 2'd0) begin
              state <= DONE;
            end else begin
              tx_sr        <= bus.i_tx_valid ? bus.i_tx_frame : '0;
              bus.o_tx_ack <= bus.i_tx_valid;
              bit_cnt      <= '0;
              rx_sr        <= '0;
              bus.o_busy   <= 1'b1;
              state        <= ACTIVE;
              if (!CPHA) bus.miso <= bus.i_tx_valid && bus.i_tx_frame[FRAME_W-1];
            end
          end
        end

        ACTIVE: begin
          if (sample_edge) begin
            rx_sr   <= rx_next[FRAME_W-2:0];
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (shift_edge && (CPHA || bit_cnt != '0)) begin
            tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
            bus.miso <= CPHA ? tx_sr[FRAME_W-1] : tx_sr[FRAME_W-2];
          end
          // Completing the last sample wins over a cs deassert seen in the same cycle.
          if (sample_edge && bit_cnt == LAST_CNT) begin
            {bus.o_cmd, bus.o_addr, bus.o_payload} <= rx_next;
            bus.o_rx_valid <= 1'b1;
            bus.o_busy     <= 1'b0;
            state          <= DONE;
            if (CPHA) bus.miso <= 1'b0;
          end else if (cs_high) begin
            bus.o_frame_err <= 1'b1;
            bus.o_busy      <= 1'b0;
            bus.miso        <= 1'b0;
            state           <= IDLE;
          end
        end

        DONE: begin
          if (shift_edge) bus.miso <= 1'b0;
          if (cs_high) begin
            bus.miso <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_frame.sv
// Drives one SPI stream into five slaves (modes 0-3 at 8/8/8, mode 0 at 4/12/16) and
// checks every pulse and field against per-slave bit counting of each cs window.
module tb_spi_slave_frame;
  localparam int H = 3;
  localparam logic [1:0] K_ACK = 2'd0, K_FRM = 2'd1, K_ERR = 2'd2, K_NONE = 2'd3;

  logic clk = 1'b0, rst = 1'b1, phase = 1'b0, cs = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [31:0] tx_frame = '0;
  logic [4:0]  miso_v, ack_v, rxv_v, err_v, busy_v;
  logic [31:0] fld_v [5];

  int          n_cmp = 0, n_fail = 0;
  logic [33:0] exp_q [5][$];
  logic [31:0] mfld [5];
  int          rx_seen [5];
  int          cnt [5];
  logic [31:0] rxbits [5], rd [5];
  logic [31:0] win_tx = '0;
  logic        win_valid = 1'b0;
  bit          dead = 1'b0;
  logic        rst_d = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : u
    localparam int CB = (g == 4) ? 4 : 8;
    localparam int AB = (g == 4) ? 12 : 8;
    localparam int PB = (g == 4) ? 16 : 8;
    localparam int FW = CB + AB + PB;
    localparam bit POL = (g == 2 || g == 3);
    localparam bit PHA = (g == 1 || g == 3);

    spi_slave_frame_if #(.CMD_BITS(CB), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)) bus ();

    assign bus.sclk       = phase ^ POL;
    assign bus.cs         = cs;
    assign bus.mosi       = mosi;
    assign bus.i_tx_frame = tx_frame[FW-1:0];
    assign bus.i_tx_valid = tx_valid;
    assign miso_v[g]      = bus.miso;
    assign ack_v[g]       = bus.o_tx_ack;
    assign rxv_v[g]       = bus.o_rx_valid;
    assign err_v[g]       = bus.o_frame_err;
    assign busy_v[g]      = bus.o_busy;
    assign fld_v[g]       = 32'({bus.o_cmd, bus.o_addr, bus.o_payload});

    spi_slave_frame #(.CMD_BITS(CB), .ADDR_BITS(AB), .PAYLOAD_BITS(PB), .CPOL(POL), .CPHA(PHA))
      dut (.sysclk(clk), .rst(rst), .bus(bus));
  end

  function automatic int fw(int i);
    return (i == 4) ? 32 : 24;
  endfunction

  function automatic bit pha(int i);
    return (i == 1 || i == 3);
  endfunction

  function automatic logic [31:0] fmask(int i);
    return (i == 4) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
  endfunction

  function automatic void chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: actual %0h required %0h", name, i, act, exp);
    end
  endfunction

  function automatic void expect_event(int i, logic [1:0] kind, string name);
    logic [33:0] e;
    logic [1:0]  head;
    head = (exp_q[i].size() == 0) ? K_NONE : exp_q[i][0][33:32];
    chk(name, i, 64'(head), 64'(kind));
    if (exp_q[i].size() > 0) begin
      e = exp_q[i].pop_front();
      if (kind == K_FRM && e[33:32] == K_FRM) mfld[i] = e[31:0];
    end
  endfunction

  // Compare process: every pulse must match the head of the slave's expected-event queue,
  // and the fields must always equal the last frame the model says completed.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        exp_q[i].delete();
        mfld[i] = '0;
        if (rst_d)
          chk("reset_outputs", i,
              64'({miso_v[i], ack_v[i], rxv_v[i], err_v[i], busy_v[i], fld_v[i]}), 64'd0);
      end else begin
        if (ack_v[i]) expect_event(i, K_ACK, "tx_ack_pulse");
        if (rxv_v[i]) begin
          rx_seen[i]++;
          expect_event(i, K_FRM, "rx_valid_pulse");
        end
        if (err_v[i]) expect_event(i, K_ERR, "frame_err_pulse");
        chk("fields", i, 64'(fld_v[i]), 64'(mfld[i]));
      end
    end
    rst_d = rst;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input bit trailing, input bit b);
    for (int i = 0; i < 5; i++) begin
      if (pha(i) == trailing && cnt[i] < fw(i)) begin
        rd[i]     = {rd[i][30:0], miso_v[i]};
        rxbits[i] = {rxbits[i][30:0], b};
        cnt[i]++;
        if (cnt[i] == fw(i) && !dead) exp_q[i].push_back({K_FRM, rxbits[i]});
      end
    end
  endtask

  task automatic close_window();
    cs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!dead) begin
        if (cnt[i] < fw(i)) exp_q[i].push_back({K_ERR, 32'h0});
        else chk("miso_read", i, 64'(rd[i]), 64'(win_valid ? (win_tx & fmask(i)) : 32'h0));
      end
    end
  endtask

  task automatic open_window(input logic [31:0] tx, input bit vld);
    tx_frame  = tx;
    tx_valid  = vld;
    win_tx    = tx;
    win_valid = vld;
    for (int i = 0; i < 5; i++) begin
      cnt[i]    = 0;
      rxbits[i] = '0;
      rd[i]     = '0;
      if (vld) exp_q[i].push_back({K_ACK, 32'h0});
    end
    tick(2);
    cs = 1'b0;
    tick(8);
    tx_frame = ~tx;   // must not disturb the frame already captured
    for (int i = 0; i < 5; i++) chk("busy_in_frame", i, 64'(busy_v[i]), 64'd1);
  endtask

  task automatic clock_bit(input bit b, input bit cs_with_last);
    mosi = b;
    tick(H);
    phase = 1'b1;
    sample(1'b0, b);
    tick(2 * H);
    phase = 1'b0;
    sample(1'b1, b);
    if (cs_with_last) close_window();
    tick(H);
  endtask

  task automatic finish_window();
    if (cs == 1'b0) begin
      tick(2);
      close_window();
    end
    tick(10);
    for (int i = 0; i < 5; i++) chk("busy_idle", i, 64'(busy_v[i]), 64'd0);
    dead     = 1'b0;
    tx_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] data, input int nbits, input logic [31:0] tx,
                      input bit vld, input bit simul);
    open_window(tx, vld);
    for (int k = 0; k < nbits; k++) clock_bit(data[nbits-1-k], simul && (k == nbits - 1));
    finish_window();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          seen0;
    logic [23:0] d24;
    logic [63:0] rdata;
    int          nb;

    for (int i = 0; i < 5; i++) rx_seen[i] = 0;
    tick(5);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 5; i++) chk("idle_miso", i, 64'(miso_v[i]), 64'd0);

    send(64'hA5_3C0F, 24, 32'h12_3456, 1'b1, 1'b0);
    chk("t1_fields", 0, 64'(fld_v[0]), 64'hA5_3C0F);
    chk("t1_read", 0, 64'(rd[0]), 64'h12_3456);

    send(64'h01_FF80, 24, 32'hC3_007E, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      chk("modes_fields", i, 64'(fld_v[i]), 64'h01_FF80);
      chk("modes_read", i, 64'(rd[i]), 64'hC3_007E);
    end

    send(64'h5ABC_1234, 32, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("wide_fields", 4, 64'(fld_v[4]), 64'h5ABC_1234);
    chk("wide_read", 4, 64'(rd[4]), 64'hDEAD_BEEF);
    chk("first24_of_32", 0, 64'(fld_v[0]), 64'h5A_BC12);

    send(64'h3FF, 10, 32'h0F0F_0F0F, 1'b1, 1'b0);
    chk("abort_keeps_fields", 0, 64'(fld_v[0]), 64'h5A_BC12);
    chk("abort_keeps_fields", 4, 64'(fld_v[4]), 64'h5ABC_1234);

    send(64'h96_E1D2, 24, 32'h00FF_FF00, 1'b1, 1'b1);
    chk("cs_with_final_sample", 3, 64'(fld_v[3]), 64'h96_E1D2);
    chk("after_abort_fields", 0, 64'(fld_v[0]), 64'h96_E1D2);

    seen0 = rx_seen[0];
    send({38'h0, 24'h7E_8118, 2'b11}, 26, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("extra_pulses_one_valid", 0, 64'(rx_seen[0] - seen0), 64'd1);
    chk("extra_pulses_fields", 0, 64'(fld_v[0]), 64'h7E_8118);
    chk("no_valid_read_zero", 0, 64'(rd[0]), 64'd0);

    d24 = 24'hC0_FFEE;
    open_window(32'hA5A5_A5A5, 1'b1);
    for (int k = 0; k < 12; k++) clock_bit(d24[23-k], 1'b0);
    dead = 1'b1;
    rst  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int k = 12; k < 24; k++) clock_bit(d24[23-k], 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_miso", i, 64'(miso_v[i]), 64'd0);
      chk("post_rst_busy", i, 64'(busy_v[i]), 64'd0);
      chk("post_rst_fields", i, 64'(fld_v[i]), 64'd0);
    end
    finish_window();

    send(64'h12_3456, 24, 32'h65_4321, 1'b1, 1'b0);
    chk("after_rst_fields", 0, 64'(fld_v[0]), 64'h12_3456);
    chk("after_rst_fields", 2, 64'(fld_v[2]), 64'h12_3456);
    chk("after_rst_read", 2, 64'(rd[2]), 64'h65_4321);

    repeat (14) begin
      rdata = {$urandom, $urandom};
      nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : int'($urandom_range(24, 34));
      send(rdata, nb, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    tick(20);
    for (int i = 0; i < 5; i++) chk("pending_events", i, 64'(exp_q[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
